// File: rtl/spi_reg_frame.sv
// spi_reg_frame: byte-level command framer behind an SPI slave.
// Each chip-select frame is one command byte followed by four big-endian data bytes.
// A command byte has bit7 = R/W (1 = read) and bits 6:0 = register address.
// Write frames produce a one-cycle wr_en_o with a 32-bit word. Read frames fetch
// rd_data_i once and present it MSB-first on tx_data_o.
//
// Ports
//   sys_clk      system clock
//   sys_rst_n    asynchronous active-low reset
//   cs_i         chip select, active-low, already synchronous to sys_clk
//   rx_valid_i   one-cycle strobe: rx_data_i holds a received byte
//   rx_data_i    received byte
//   tx_data_o    next byte for the slave to shift out
//   wr_en_o      one-cycle register write strobe
//   wr_addr_o    write address, held until the next write
//   wr_data_o    write data, held until the next write
//   rd_addr_o    read address to the register bank (latched command address)
//   rd_data_i    combinational read data for rd_addr_o
//   frame_err_o  one-cycle pulse on a malformed frame
//   busy_o       high while a frame is being parsed
module spi_reg_frame #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cs_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic [7:0]        tx_data_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i,
  output logic              frame_err_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWdata,
    StWrCommit,
    StRdFetch,
    StRdata,
    StWaitCs
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              err_q, err_d;
  logic              addr_ok;

  // Address bits above ADDR_W must be zero.
  assign addr_ok = ((rx_data_i[6:0] >> ADDR_W) == 7'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    shadow_d  = shadow_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;

    // All four data bytes are in by WR_COMMIT, so the write completes even if cs rises then.
    if (state_q == StWrCommit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = acc_q;
    end

    if (cs_i && (state_q != StIdle)) begin
      // cs high wins over a same-cycle byte; the byte is dropped.
      state_d = StIdle;
      cnt_d   = 2'd0;
      if ((state_q == StWdata) || ((state_q == StRdata) && (cnt_q != 2'd0))) begin
        err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!cs_i) state_d = StCmd;
        end
        StCmd: begin
          if (rx_valid_i) begin
            addr_d = rx_data_i[ADDR_W-1:0];
            cnt_d  = 2'd0;
            if (!addr_ok) begin
              err_d   = 1'b1;
              state_d = StWaitCs;
            end else if (rx_data_i[7]) begin
              state_d = StRdFetch;
            end else begin
              state_d = StWdata;
            end
          end
        end
        StWdata: begin
          if (rx_valid_i) begin
            acc_d = {acc_q[23:0], rx_data_i};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = StWrCommit;
          end
        end
        StWrCommit: begin
          state_d = StWaitCs;
        end
        StRdFetch: begin
          shadow_d = rd_data_i;
          state_d  = StRdata;
        end
        StRdata: begin
          if (rx_valid_i) begin
            shadow_d = {shadow_q[23:0], 8'h00};
            cnt_d    = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = StWaitCs;
          end
        end
        StWaitCs: begin
          if (rx_valid_i) err_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      acc_q     <= 32'd0;
      shadow_q  <= 32'd0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shadow_q  <= shadow_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == StRdata) tx_data_o = shadow_q[31:24];
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign rd_addr_o   = addr_q;
  assign frame_err_o = err_q;
  assign busy_o      = (state_q != StIdle);

endmodule
